// File: rtl/uart_rx_packet_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_packet_ctrl
// Description : Frame parser downstream of a byte-level UART receiver.
//               Hunts for SYNC_BYTE, then parses CMD, LEN, LEN payload
//               bytes and an 8-bit additive checksum. Good payloads are held
//               in an internal buffer behind a valid/ack handshake; bad,
//               stalled or unacknowledged traffic is dropped and flagged.
//               Optional feature macro: UART_PKT_TIMEOUT_EN (inter-byte
//               timeout; when undefined err_timeout is tied low).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 5000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rec,
    input  logic [7:0] uart_data_in,
    output logic       pkt_valid,
    input  logic       pkt_ack,
    output logic [7:0] pkt_cmd,
    output logic [7:0] pkt_len,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       err_cksum,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_drop
);

    localparam int         c_AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [8:0] c_MAX_LEN = 9'(MAX_LEN);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CMD   = 3'd1;
    localparam logic [2:0] c_ST_LEN   = 3'd2;
    localparam logic [2:0] c_ST_DATA  = 3'd3;
    localparam logic [2:0] c_ST_CKSUM = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    // Elaboration-time range checks on the configuration.
    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("uart_rx_packet_ctrl: MAX_LEN must be 1..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 24'hFF_FFFF) begin : g_bad_timeout
        $error("uart_rx_packet_ctrl: TIMEOUT must be 1..2^24-1");
    end

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       r_rec_d;
    logic       w_byte_ev;
    logic [7:0] r_cmd;
    logic [7:0] r_len;
    logic [7:0] r_sum;
    logic [7:0] r_idx;
    logic [7:0] r_buf [MAX_LEN];
    logic [7:0] r_rd_data;
    logic       r_err_cksum;
    logic       r_err_len;
    logic       r_err_drop;
    logic       w_busy;
    logic       w_timeout;
    logic       w_ld_cmd;
    logic       w_ld_len;
    logic       w_wr_buf;
    logic       w_err_cksum;
    logic       w_err_len;
    logic       w_err_drop;

    // A new byte is a rising edge of the receiver's completion flag.
    assign w_byte_ev = uart_rec & ~r_rec_d;
    assign w_busy    = (r_state == c_ST_CMD)  || (r_state == c_ST_LEN) ||
                       (r_state == c_ST_DATA) || (r_state == c_ST_CKSUM);

    // Edge-detect history; resets high so a flag already high at release is not a byte.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_rec_d <= 1'b1;
        else         r_rec_d <= uart_rec;
    end

`ifdef UART_PKT_TIMEOUT_EN
    localparam logic [23:0] c_TMO_LAST = 24'(TIMEOUT - 1);
    logic [23:0] r_tmo_cnt;
    logic        r_err_tmo;

    // Inter-byte stall counter: restarts on each byte, idles outside a frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || w_byte_ev || !w_busy) r_tmo_cnt <= 24'd0;
        else                                 r_tmo_cnt <= r_tmo_cnt + 24'd1;
    end

    // A byte arriving on the expiry cycle wins, so expiry requires no event.
    assign w_timeout = w_busy & ~w_byte_ev & (r_tmo_cnt == c_TMO_LAST);

    // Registered timeout pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_err_tmo <= 1'b0;
        else         r_err_tmo <= w_timeout;
    end
    assign err_timeout = r_err_tmo;
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= c_ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state decode and datapath strobes for the frame parser.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_cmd    = 1'b0;
        w_ld_len    = 1'b0;
        w_wr_buf    = 1'b0;
        w_err_cksum = 1'b0;
        w_err_len   = 1'b0;
        w_err_drop  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_byte_ev && (uart_data_in == SYNC_BYTE)) w_state_nxt = c_ST_CMD;
            end
            c_ST_CMD: begin
                if (w_byte_ev) begin
                    w_ld_cmd    = 1'b1;
                    w_state_nxt = c_ST_LEN;
                end
            end
            c_ST_LEN: begin
                if (w_byte_ev) begin
                    if ({1'b0, uart_data_in} > c_MAX_LEN) begin
                        w_err_len   = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_ld_len    = 1'b1;
                        w_state_nxt = (uart_data_in == 8'd0) ? c_ST_CKSUM : c_ST_DATA;
                    end
                end
            end
            c_ST_DATA: begin
                if (w_byte_ev) begin
                    w_wr_buf = 1'b1;
                    if (r_idx + 8'd1 == r_len) w_state_nxt = c_ST_CKSUM;
                end
            end
            c_ST_CKSUM: begin
                if (w_byte_ev) begin
                    if (uart_data_in == r_sum) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_err_cksum = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            c_ST_DONE: begin
                // Held frame is frozen: any byte here is discarded, even SYNC.
                if (w_byte_ev) w_err_drop  = 1'b1;
                if (pkt_ack)   w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        if (w_timeout) w_state_nxt = c_ST_IDLE;
    end

    // Header capture, running checksum and payload index.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cmd <= 8'd0;
            r_len <= 8'd0;
            r_sum <= 8'd0;
            r_idx <= 8'd0;
        end else begin
            if (w_ld_cmd) begin
                r_cmd <= uart_data_in;
                r_sum <= uart_data_in;
            end
            if (w_ld_len) begin
                r_len <= uart_data_in;
                r_sum <= r_sum + uart_data_in;
                r_idx <= 8'd0;
            end
            if (w_wr_buf) begin
                r_sum <= r_sum + uart_data_in;
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    // Payload buffer write port; contents are don't-care after reset.
    always_ff @(posedge sys_clk) begin
        if (w_wr_buf) r_buf[r_idx[c_AW-1:0]] <= uart_data_in;
    end

    // Registered read port; addresses beyond the buffer read as zero.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)                        r_rd_data <= 8'd0;
        else if ({1'b0, rd_addr} < c_MAX_LEN) r_rd_data <= r_buf[rd_addr[c_AW-1:0]];
        else                                r_rd_data <= 8'd0;
    end

    // Registered single-cycle error pulses.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_err_cksum <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_drop  <= 1'b0;
        end else begin
            r_err_cksum <= w_err_cksum;
            r_err_len   <= w_err_len;
            r_err_drop  <= w_err_drop;
        end
    end

    assign pkt_valid = (r_state == c_ST_DONE);
    assign pkt_cmd   = r_cmd;
    assign pkt_len   = r_len;
    assign rd_data   = r_rd_data;
    assign busy      = w_busy;
    assign err_cksum = r_err_cksum;
    assign err_len   = r_err_len;
    assign err_drop  = r_err_drop;

endmodule
`default_nettype wire
